// File: rtl/fft_pair_loader.sv
// Input frame buffer for the FFT: serial sample writes, then paired (k, k+HALF) reads
// that feed the first radix-2 DIF butterfly stage.
module fft_pair_loader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wren,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rden,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic              valid_out,
    output logic              full,
    output logic              done
);
    localparam int HALF = DEPTH / 2;
    localparam int AW   = $clog2(DEPTH);
    localparam int RW   = $clog2(HALF);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t            state_q;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [RW-1:0]     rd_idx_q, rd_idx_d;
    logic              full_q, valid_q, done_q;
    logic [DATA_W-1:0] d1_q, d2_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // Power-of-two sizes make the increment wrap to 0 at the end of a frame.
    assign wr_addr_d = wr_addr_q + 1'b1;
    assign rd_idx_d  = rd_idx_q + 1'b1;

    // Memory is not reset; a frame is only readable after a complete fill.
    always_ff @(posedge clk) begin
        if (!rst && state_q == FILL && wren)
            mem[wr_addr_q] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            wr_addr_q <= '0;
            rd_idx_q  <= '0;
            full_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            d1_q      <= '0;
            d2_q      <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                FILL: begin
                    if (wren) begin
                        wr_addr_q <= wr_addr_d;
                        if (&wr_addr_q) begin
                            state_q <= DRAIN;
                            full_q  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (rden) begin
                        d1_q     <= mem[{1'b0, rd_idx_q}];
                        d2_q     <= mem[{1'b1, rd_idx_q}];
                        valid_q  <= 1'b1;
                        rd_idx_q <= rd_idx_d;
                        if (&rd_idx_q) begin
                            done_q  <= 1'b1;
                            state_q <= FILL;
                            full_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign data_out1 = d1_q;
    assign data_out2 = d2_q;
    assign valid_out = valid_q;
    assign full      = full_q;
    assign done      = done_q;
endmodule

// File: tb/tb_fft_pair_loader.sv
// Bench for fft_pair_loader: per-cycle scoreboard from a frame model plus
// table-driven frame scenarios checked against constant pair patterns.
module tb_fft_pair_loader;
    localparam int DW = 32;
    localparam int N  = 64;
    localparam int H  = 32;
    localparam logic [DW-1:0] JUNK = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wren = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rden = 1'b0;
    logic [DW-1:0] data_out1, data_out2;
    logic          valid_out, full, done;

    fft_pair_loader #(.DATA_W(DW), .DEPTH(N)) dut (
        .clk(clk), .rst(rst), .wren(wren), .data_in(data_in), .rden(rden),
        .data_out1(data_out1), .data_out2(data_out2), .valid_out(valid_out),
        .full(full), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic          dn;
        logic          fl;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } exp_t;

    typedef struct {
        int            base;
        bit            gap;
        bit            fill_rden;
        bit            last_rden;
        bit            junk;
        logic [DW-1:0] exp_first1;
        logic [DW-1:0] exp_last2;
    } vec_t;

    exp_t          sb[$];
    logic [DW-1:0] cap1[$], cap2[$];
    int            cap_done;
    int            checks = 0;
    int            failures = 0;

    // Reference model state
    bit            m_drain;
    int            m_wa, m_ri;
    logic [DW-1:0] m_mem [N];
    logic [DW-1:0] m_d1 = '0, m_d2 = '0;

    task automatic cyc(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
        exp_t e;
        rst = r; wren = w; data_in = d; rden = rd;
        @(posedge clk);
        e.valid = 1'b0; e.dn = 1'b0;
        if (r) begin
            m_drain = 0; m_wa = 0; m_ri = 0; m_d1 = '0; m_d2 = '0;
        end else if (!m_drain) begin
            if (w) begin
                m_mem[m_wa] = d;
                if (m_wa == N-1) begin m_wa = 0; m_drain = 1; end
                else m_wa++;
            end
        end else if (rd) begin
            m_d1 = m_mem[m_ri]; m_d2 = m_mem[m_ri+H];
            e.valid = 1'b1;
            if (m_ri == H-1) begin e.dn = 1'b1; m_ri = 0; m_drain = 0; end
            else m_ri++;
        end
        e.fl = m_drain; e.d1 = m_d1; e.d2 = m_d2;
        sb.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (valid_out !== e.valid || done !== e.dn || full !== e.fl ||
                data_out1 !== e.d1 || data_out2 !== e.d2) begin
                failures++;
                $display("FAIL cycle_sb t=%0t got v=%b d=%b f=%b o1=%h o2=%h want v=%b d=%b f=%b o1=%h o2=%h",
                         $time, valid_out, done, full, data_out1, data_out2,
                         e.valid, e.dn, e.fl, e.d1, e.d2);
            end
        end
        if (valid_out === 1'b1) begin
            cap1.push_back(data_out1);
            cap2.push_back(data_out2);
            if (done === 1'b1) cap_done++;
            checks++;
            if (data_out1 === JUNK || data_out2 === JUNK) begin
                failures++;
                $display("FAIL no_junk got o1=%h o2=%h want neither %h", data_out1, data_out2, JUNK);
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int i, reads, j;
        bit ph;
        cap1.delete(); cap2.delete(); cap_done = 0;
        i = 0; ph = 0;
        while (i < N) begin
            if (v.gap && ph) begin
                cyc(0, 0, JUNK, v.fill_rden);
            end else begin
                cyc(0, 1, DW'(v.base + i),
                    (i == N-1) ? v.last_rden : (v.fill_rden && (i % 3 == 0)));
                i++;
            end
            ph = ~ph;
        end
        if (v.last_rden) cyc(0, 0, '0, 0);
        reads = 0;
        if (v.junk) begin
            for (j = 0; j < 10; j++) begin
                cyc(0, 1, JUNK, j[0]);
                if (j[0]) reads++;
            end
        end
        while (reads < H) begin
            cyc(0, v.junk, JUNK, 1);
            reads++;
        end
        @(negedge clk); #1;
        check("pair_count", DW'(cap1.size()), DW'(H));
        check("done_count", DW'(cap_done), 32'd1);
        if (cap1.size() == H) begin
            check("first_pair1", cap1[0], v.exp_first1);
            check("last_pair2", cap2[H-1], v.exp_last2);
            for (int k = 0; k < H; k++) begin
                check("pair_k", cap1[k], DW'(v.base + k));
                check("pair_k_half", cap2[k], DW'(v.base + k + H));
            end
        end
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{0,   0, 0, 0, 0, 32'd0,   32'd63};
        tbl[1] = '{100, 0, 0, 0, 0, 32'd100, 32'd163};
        tbl[2] = '{200, 1, 1, 0, 0, 32'd200, 32'd263};
        tbl[3] = '{300, 0, 0, 1, 0, 32'd300, 32'd363};
        tbl[4] = '{400, 0, 0, 0, 1, 32'd400, 32'd463};
        tbl[5] = '{800, 0, 1, 0, 0, 32'd800, 32'd863};

        cyc(1, 0, '0, 0);
        cyc(1, 1, 32'h5, 1);
        @(negedge clk); #1;
        check("rst_full", DW'(full), 32'd0);
        check("rst_valid", DW'(valid_out), 32'd0);
        check("rst_done", DW'(done), 32'd0);
        check("rst_out1", data_out1, 32'd0);
        check("rst_out2", data_out2, 32'd0);

        for (int t = 0; t < 5; t++) run_frame(tbl[t]);

        // Reset in the middle of a fill, then in the middle of a drain
        for (int i = 0; i < 20; i++) cyc(0, 1, DW'(500 + i), 0);
        cyc(1, 1, '0, 1);
        @(negedge clk); #1;
        check("midfill_full", DW'(full), 32'd0);
        check("midfill_valid", DW'(valid_out), 32'd0);
        for (int i = 0; i < N; i++) cyc(0, 1, DW'(700 + i), 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, '0, 1);
        cyc(1, 0, '0, 1);
        @(negedge clk); #1;
        check("middrain_full", DW'(full), 32'd0);
        check("middrain_valid", DW'(valid_out), 32'd0);

        run_frame(tbl[5]);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
